// File: rtl/adxl345_pkg.sv
// Shared register map, FSM encoding and address-class helpers for the ADXL345 SPI responder.
// Pure declarations: no latency, no flow control.
package adxl345_pkg;

  localparam logic [5:0] ADDR_DEVID       = 6'h00;
  localparam logic [5:0] ADDR_BW_RATE     = 6'h2C;
  localparam logic [5:0] ADDR_POWER_CTL   = 6'h2D;
  localparam logic [5:0] ADDR_INT_ENABLE  = 6'h2E;
  localparam logic [5:0] ADDR_INT_MAP     = 6'h2F;
  localparam logic [5:0] ADDR_INT_SOURCE  = 6'h30;
  localparam logic [5:0] ADDR_DATA_FORMAT = 6'h31;
  localparam logic [5:0] ADDR_DATAX0      = 6'h32;
  localparam logic [5:0] ADDR_DATAX1      = 6'h33;
  localparam logic [5:0] ADDR_DATAY0      = 6'h34;
  localparam logic [5:0] ADDR_DATAY1      = 6'h35;
  localparam logic [5:0] ADDR_DATAZ0      = 6'h36;
  localparam logic [5:0] ADDR_DATAZ1      = 6'h37;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CMD,
    ST_WDATA,
    ST_RDATA
  } spi_state_t;

  // RAM-backed registers: 0x1D..0x2F plus DATA_FORMAT, FIFO_CTL and FIFO_STATUS slots
  function automatic logic is_writable(input logic [5:0] a);
    return ((a >= 6'h1D) && (a <= ADDR_INT_MAP)) || (a == ADDR_DATA_FORMAT) ||
           (a == 6'h38) || (a == 6'h39);
  endfunction

  function automatic logic is_data_addr(input logic [5:0] a);
    return (a >= ADDR_DATAX0) && (a <= ADDR_DATAZ1);
  endfunction

endpackage

// File: rtl/adxl345_spi_responder_sync.sv
// Synchronizes CSN/SCLK/SDIO into iCLK and emits one-cycle SCLK rise/fall and CSN fall/rise pulses.
// Pulses appear SYNC_STAGES cycles after the pin edge; no backpressure.
module spi_edge_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic csn,
  input  logic sclk,
  input  logic sdio,
  output logic csn_s,
  output logic sdio_s,
  output logic sclk_rise,
  output logic sclk_fall,
  output logic csn_fall,
  output logic csn_rise
);

  logic [SYNC_STAGES-1:0] csn_q;
  logic [SYNC_STAGES-1:0] sclk_q;
  logic [SYNC_STAGES-1:0] sdio_q;
  logic                   csn_prev;
  logic                   sclk_prev;
  logic                   sclk_s;

  // CSN and SCLK reset to their idle-high levels so leaving reset makes no false edge
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      csn_q     <= '1;
      sclk_q    <= '1;
      sdio_q    <= '0;
      csn_prev  <= 1'b1;
      sclk_prev <= 1'b1;
    end else begin
      csn_q     <= {csn_q[SYNC_STAGES-2:0], csn};
      sclk_q    <= {sclk_q[SYNC_STAGES-2:0], sclk};
      sdio_q    <= {sdio_q[SYNC_STAGES-2:0], sdio};
      csn_prev  <= csn_s;
      sclk_prev <= sclk_s;
    end
  end

  assign csn_s     = csn_q[SYNC_STAGES-1];
  assign sclk_s    = sclk_q[SYNC_STAGES-1];
  assign sdio_s    = sdio_q[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_prev;
  assign sclk_fall = ~sclk_s & sclk_prev;
  assign csn_fall  = ~csn_s & csn_prev;
  assign csn_rise  = csn_s & ~csn_prev;

endmodule

// File: rtl/adxl345_spi_responder.sv
// Register-level ADXL345 emulator on 3-wire SPI mode 3, oversampled on iCLK (>= 8x SCLK).
// Acts SYNC_STAGES+1 cycles after each pin edge; the initiator paces everything, no backpressure.
module adxl345_spi_responder
  import adxl345_pkg::*;
#(
  parameter int         SYNC_STAGES = 2,
  parameter logic [7:0] DEVID_VAL   = 8'hE5,
  parameter logic [7:0] BW_RATE_RST = 8'h0A
) (
  input  logic        iCLK,
  input  logic        iRSTN,
  input  logic        iSPI_CSN,
  input  logic        iSPI_CLK,
  input  logic        iSDIO,
  output logic        oSDIO,
  output logic        oSDIO_OE,
  input  logic [15:0] iDATA_X,
  input  logic [15:0] iDATA_Y,
  input  logic [15:0] iDATA_Z,
  input  logic        iSAMPLE_VALID,
  output logic        oINT2,
  output logic        oREG_WE,
  output logic [5:0]  oREG_ADDR,
  output logic [7:0]  oREG_WDATA,
  output logic        oBUSY
);

  logic csn_s, sdio_s, sclk_rise, sclk_fall, csn_fall, csn_rise;

  spi_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk      (iCLK),
    .rst_n    (iRSTN),
    .csn      (iSPI_CSN),
    .sclk     (iSPI_CLK),
    .sdio     (iSDIO),
    .csn_s    (csn_s),
    .sdio_s   (sdio_s),
    .sclk_rise(sclk_rise),
    .sclk_fall(sclk_fall),
    .csn_fall (csn_fall),
    .csn_rise (csn_rise)
  );

  spi_state_t  state;
  logic [3:0]  bit_cnt;
  logic [7:0]  shift_in;
  logic [7:0]  shift_out;
  logic [5:0]  addr;
  logic        mb;
  logic        sdio_oe;
  logic        data_read;
  logic        reg_we;
  logic [5:0]  reg_addr;
  logic [7:0]  reg_wdata;
  logic        int2;
  logic [7:0]  regs [64];
  logic [15:0] shadow_x, shadow_y, shadow_z;
  logic [15:0] pend_x, pend_y, pend_z;
  logic        pend_vld;
  logic        data_ready;

  logic [7:0]  next_byte;
  logic [5:0]  next_addr;

  assign next_byte = {shift_in[6:0], sdio_s};
  assign next_addr = mb ? addr + 6'd1 : addr;

  function automatic logic [7:0] read_reg(input logic [5:0] a);
    logic [7:0] r;
    case (a)
      ADDR_DEVID:      r = DEVID_VAL;
      ADDR_INT_SOURCE: r = {data_ready, 7'b0};
      ADDR_DATAX0:     r = shadow_x[7:0];
      ADDR_DATAX1:     r = shadow_x[15:8];
      ADDR_DATAY0:     r = shadow_y[7:0];
      ADDR_DATAY1:     r = shadow_y[15:8];
      ADDR_DATAZ0:     r = shadow_z[7:0];
      ADDR_DATAZ1:     r = shadow_z[15:8];
      default:         r = is_writable(a) ? regs[a] : 8'h00;
    endcase
    return r;
  endfunction

  always_ff @(posedge iCLK) begin
    if (!iRSTN) begin
      state      <= ST_IDLE;
      bit_cnt    <= 4'd0;
      shift_in   <= 8'h00;
      shift_out  <= 8'h00;
      addr       <= 6'd0;
      mb         <= 1'b0;
      sdio_oe    <= 1'b0;
      data_read  <= 1'b0;
      reg_we     <= 1'b0;
      reg_addr   <= 6'd0;
      reg_wdata  <= 8'h00;
      int2       <= 1'b0;
      for (int i = 0; i < 64; i++) regs[i] <= 8'h00;
      regs[ADDR_BW_RATE] <= BW_RATE_RST;
      shadow_x   <= 16'h0;
      shadow_y   <= 16'h0;
      shadow_z   <= 16'h0;
      pend_x     <= 16'h0;
      pend_y     <= 16'h0;
      pend_z     <= 16'h0;
      pend_vld   <= 1'b0;
      data_ready <= 1'b0;
    end else begin
      reg_we <= 1'b0;
      int2   <= data_ready & regs[ADDR_INT_ENABLE][7] & regs[ADDR_INT_MAP][7];

      if (csn_rise) begin
        state     <= ST_IDLE;
        sdio_oe   <= 1'b0;
        shift_out <= 8'h00;
        bit_cnt   <= 4'd0;
        data_read <= 1'b0;
        if (pend_vld) begin
          shadow_x   <= pend_x;
          shadow_y   <= pend_y;
          shadow_z   <= pend_z;
          data_ready <= 1'b1;
          pend_vld   <= 1'b0;
        end else if (data_read) begin
          data_ready <= 1'b0;
        end
      end else begin
        case (state)
          ST_IDLE: if (csn_fall) begin
            state     <= ST_CMD;
            bit_cnt   <= 4'd0;
            shift_in  <= 8'h00;
            data_read <= 1'b0;
          end
          ST_CMD: if (sclk_rise) begin
            shift_in <= next_byte;
            bit_cnt  <= bit_cnt + 4'd1;
            if (bit_cnt == 4'd7) begin
              bit_cnt <= 4'd0;
              mb      <= next_byte[6];
              addr    <= next_byte[5:0];
              if (next_byte[7]) begin
                state     <= ST_RDATA;
                shift_out <= read_reg(next_byte[5:0]);
                sdio_oe   <= 1'b1;
              end else begin
                state <= ST_WDATA;
              end
            end
          end
          ST_WDATA: if (sclk_rise) begin
            shift_in <= next_byte;
            bit_cnt  <= bit_cnt + 4'd1;
            if (bit_cnt == 4'd7) begin
              bit_cnt <= 4'd0;
              if (is_writable(addr)) begin
                regs[addr] <= next_byte;
                reg_we     <= 1'b1;
                reg_addr   <= addr;
                reg_wdata  <= next_byte;
              end
              addr <= next_addr;
            end
          end
          // bit_cnt counts bits the initiator has sampled; the falling edge right after
          // the command byte must not shift, since the MSB is already on the wire
          ST_RDATA: if (sclk_rise) begin
            bit_cnt <= bit_cnt + 4'd1;
            if (bit_cnt == 4'd7 && is_data_addr(addr)) data_read <= 1'b1;
          end else if (sclk_fall) begin
            if (bit_cnt == 4'd8) begin
              bit_cnt   <= 4'd0;
              addr      <= next_addr;
              shift_out <= read_reg(next_addr);
            end else if (bit_cnt != 4'd0) begin
              shift_out <= {shift_out[6:0], 1'b0};
            end
          end
          default: state <= ST_IDLE;
        endcase
      end

      // Placed last so a direct capture beats any pending apply or clear in the same cycle
      if (iSAMPLE_VALID) begin
        if (csn_s) begin
          shadow_x   <= iDATA_X;
          shadow_y   <= iDATA_Y;
          shadow_z   <= iDATA_Z;
          data_ready <= 1'b1;
        end else begin
          pend_x   <= iDATA_X;
          pend_y   <= iDATA_Y;
          pend_z   <= iDATA_Z;
          pend_vld <= 1'b1;
        end
      end
    end
  end

  assign oSDIO      = shift_out[7];
  assign oSDIO_OE   = sdio_oe;
  assign oINT2      = int2;
  assign oREG_WE    = reg_we;
  assign oREG_ADDR  = reg_addr;
  assign oREG_WDATA = reg_wdata;
  assign oBUSY      = ~csn_s;

endmodule

// File: tb/tb_adxl345_spi_responder.sv
// Directed bench: an SPI mode-3 initiator drives frames, scoreboards check read bytes and register writes.
module tb_adxl345_spi_responder;

  localparam int HALF = 5;
  localparam int SYNC = 2;

  logic        iCLK = 1'b0;
  logic        iRSTN = 1'b0;
  logic        iSPI_CSN = 1'b1;
  logic        iSPI_CLK = 1'b1;
  logic        iSDIO = 1'b0;
  logic        oSDIO, oSDIO_OE, oINT2, oREG_WE, oBUSY;
  logic [5:0]  oREG_ADDR;
  logic [7:0]  oREG_WDATA;
  logic [15:0] iDATA_X = 16'h0, iDATA_Y = 16'h0, iDATA_Z = 16'h0;
  logic        iSAMPLE_VALID = 1'b0;

  always #10 iCLK = ~iCLK;

  adxl345_spi_responder #(.SYNC_STAGES(SYNC), .DEVID_VAL(8'hE5), .BW_RATE_RST(8'h0A)) dut (
    .iCLK(iCLK), .iRSTN(iRSTN), .iSPI_CSN(iSPI_CSN), .iSPI_CLK(iSPI_CLK), .iSDIO(iSDIO),
    .oSDIO(oSDIO), .oSDIO_OE(oSDIO_OE), .iDATA_X(iDATA_X), .iDATA_Y(iDATA_Y),
    .iDATA_Z(iDATA_Z), .iSAMPLE_VALID(iSAMPLE_VALID), .oINT2(oINT2), .oREG_WE(oREG_WE),
    .oREG_ADDR(oREG_ADDR), .oREG_WDATA(oREG_WDATA), .oBUSY(oBUSY)
  );

  int         checks = 0;
  int         failures = 0;
  int         we_seen = 0;
  logic [7:0] exp_rd [$];
  logic [13:0] exp_we [$];
  logic [7:0] rd_sh = 8'h00;
  int         rd_n = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Read-data monitor: collects SDIO bits the initiator samples while the DUT drives the pin
  always @(posedge iSPI_CLK or posedge iSPI_CSN) begin
    if (iSPI_CSN) begin
      rd_n = 0;
    end else if (oSDIO_OE === 1'b1) begin
      rd_sh = {rd_sh[6:0], oSDIO};
      rd_n++;
      if (rd_n == 8) begin
        rd_n = 0;
        if (exp_rd.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL rd_unexpected: got %0h expected none", rd_sh);
        end else begin
          chk("rd_byte", rd_sh, exp_rd.pop_front());
        end
      end
    end
  end

  // Register-write monitor
  always @(negedge iCLK) begin
    if (oREG_WE === 1'b1) begin
      we_seen++;
      if (exp_we.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL we_unexpected: got %0h/%0h expected none", oREG_ADDR, oREG_WDATA);
      end else begin
        chk("reg_we", {oREG_ADDR, oREG_WDATA}, exp_we.pop_front());
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge iCLK);
  endtask

  task automatic csn_low();
    @(negedge iCLK);
    iSPI_CSN = 1'b0;
    cyc(4);
  endtask

  task automatic csn_high();
    cyc(HALF);
    iSPI_CSN = 1'b1;
    iSDIO = 1'b0;
    cyc(10);
  endtask

  task automatic send_bits(input logic [63:0] v, input int n);
    for (int i = 0; i < n; i++) begin
      iSPI_CLK = 1'b0;
      iSDIO = v[63-i];
      cyc(HALF);
      iSPI_CLK = 1'b1;
      cyc(HALF);
    end
  endtask

  task automatic read_frame(input logic [7:0] cmd, input int nbytes);
    csn_low();
    send_bits({cmd, 56'h0}, 8 + 8 * nbytes);
    csn_high();
  endtask

  task automatic write_frame(input logic [7:0] cmd, input logic [55:0] data, input int nbits);
    csn_low();
    send_bits({cmd, data}, 8 + nbits);
    csn_high();
  endtask

  task automatic pulse_sample(input logic [15:0] x, input logic [15:0] y, input logic [15:0] z);
    iDATA_X = x;
    iDATA_Y = y;
    iDATA_Z = z;
    iSAMPLE_VALID = 1'b1;
    cyc(1);
    iSAMPLE_VALID = 1'b0;
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int we_before;
    cyc(4);
    chk("rst_sdio", oSDIO, 0);
    chk("rst_oe", oSDIO_OE, 0);
    chk("rst_int2", oINT2, 0);
    chk("rst_we", oREG_WE, 0);
    chk("rst_addr", oREG_ADDR, 0);
    chk("rst_wdata", oREG_WDATA, 0);
    chk("rst_busy", oBUSY, 0);
    iRSTN = 1'b1;
    cyc(4);

    // DEVID with OE only during the data phase
    exp_rd.push_back(8'hE5);
    csn_low();
    send_bits({8'h80, 56'h0}, 7);
    chk("devid_oe_cmd", oSDIO_OE, 0);
    chk("devid_busy", oBUSY, 1);
    send_bits(64'h0, 9);
    chk("devid_oe_data", oSDIO_OE, 1);
    iSPI_CSN = 1'b1;
    cyc(SYNC + 2);
    chk("devid_oe_off", oSDIO_OE, 0);
    chk("devid_busy_off", oBUSY, 0);
    cyc(6);

    // MB=0 holds the address; MB=1 wraps 0x3F -> 0x00
    exp_rd.push_back(8'hE5); exp_rd.push_back(8'hE5);
    read_frame(8'h80, 2);
    exp_rd.push_back(8'h00); exp_rd.push_back(8'hE5);
    read_frame(8'hFF, 2);

    // Write/read back, then a write to read-only DEVID
    exp_we.push_back({6'h31, 8'h0B});
    write_frame(8'h31, {8'h0B, 48'h0}, 8);
    exp_rd.push_back(8'h0B);
    read_frame(8'hB1, 1);
    we_before = we_seen;
    write_frame(8'h00, {8'h12, 48'h0}, 8);
    chk("devid_wr_ignored", we_seen, we_before);
    exp_rd.push_back(8'hE5);
    read_frame(8'h80, 1);

    // Multi-byte data read and INT_SOURCE before/after
    pulse_sample(16'hFF00, 16'h0100, 16'h8001);
    cyc(3);
    exp_rd.push_back(8'h80);
    read_frame(8'hB0, 1);
    exp_rd.push_back(8'h00); exp_rd.push_back(8'hFF); exp_rd.push_back(8'h00);
    exp_rd.push_back(8'h01); exp_rd.push_back(8'h01); exp_rd.push_back(8'h80);
    read_frame(8'hF2, 6);
    exp_rd.push_back(8'h00);
    read_frame(8'hB0, 1);

    // Sample arriving mid-burst is deferred to the CSN rising edge
    pulse_sample(16'h0001, 16'h0000, 16'h0000);
    cyc(3);
    exp_rd.push_back(8'h01); exp_rd.push_back(8'h00);
    fork
      read_frame(8'hF2, 2);
      begin
        cyc(100);
        pulse_sample(16'h1234, 16'h0000, 16'h0000);
      end
    join
    exp_rd.push_back(8'h80);
    read_frame(8'hB0, 1);
    exp_rd.push_back(8'h34); exp_rd.push_back(8'h12);
    read_frame(8'hF2, 2);
    exp_rd.push_back(8'h00);
    read_frame(8'hB0, 1);

    // Partial write byte is discarded
    we_before = we_seen;
    write_frame(8'h2E, {5'b11111, 51'h0}, 5);
    chk("abort_no_we", we_seen, we_before);
    exp_rd.push_back(8'h00);
    read_frame(8'hAE, 1);

    // Interrupt path, with an auto-increment write to INT_ENABLE/INT_MAP
    exp_we.push_back({6'h2E, 8'h80}); exp_we.push_back({6'h2F, 8'h80});
    write_frame(8'h6E, {8'h80, 8'h80, 40'h0}, 16);
    chk("int2_idle", oINT2, 0);
    pulse_sample(16'h0055, 16'h0000, 16'h0000);
    chk("int2_latency", oINT2, 0);
    cyc(1);
    chk("int2_set", oINT2, 1);
    exp_rd.push_back(8'h55);
    read_frame(8'hB2, 1);
    chk("int2_clr", oINT2, 0);

    // Reset in the middle of a read
    csn_low();
    send_bits({8'h80, 56'h0}, 11);
    chk("mid_rd_oe", oSDIO_OE, 1);
    iRSTN = 1'b0;
    cyc(1);
    chk("rst_mid_rd_oe", oSDIO_OE, 0);
    cyc(2);
    iSPI_CSN = 1'b1;
    cyc(2);
    iRSTN = 1'b1;
    cyc(5);
    exp_rd.push_back(8'h0A);
    read_frame(8'hAC, 1);
    exp_rd.push_back(8'h00);
    read_frame(8'hB1, 1);

    cyc(10);
    chk("rd_queue_drained", exp_rd.size(), 0);
    chk("we_queue_drained", exp_we.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
